// File: rtl/timer_pkg.sv
// Shared types, constants and BCD arithmetic helpers for the MM:SS countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_e;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t min_t;
    bcd_t min_o;
    bcd_t sec_t;
    bcd_t sec_o;
  } time_t;

  localparam bcd_t  SEC_TENS_MAX = 4'd5;
  localparam bcd_t  BCD_MAX      = 4'd9;
  localparam time_t TIME_ZERO    = 16'h0000;
  localparam time_t TIME_ONE     = 16'h0001;

  // Two-digit BCD increment, wrapping from max_v back to 00.
  function automatic logic [7:0] bcd2_inc(input logic [7:0] v, input logic [7:0] max_v);
    logic [7:0] r;
    if (v == max_v)             r = 8'h00;
    else if (v[3:0] == BCD_MAX) r = {v[7:4] + 4'd1, 4'd0};
    else                        r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Two-digit BCD decrement; 00 reloads to {tens_max, 9} (the caller handles the borrow).
  function automatic logic [7:0] bcd2_dec(input logic [7:0] v, input bcd_t tens_max);
    logic [7:0] r;
    if (v == 8'h00)             r = {tens_max, BCD_MAX};
    else if (v[3:0] == 4'd0)    r = {v[7:4] - 4'd1, BCD_MAX};
    else                        r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  // One-second decrement of MM:SS with the seconds borrow rippling into minutes.
  function automatic time_t time_dec(input time_t t);
    time_t r;
    logic  borrow;
    borrow             = ({t.sec_t, t.sec_o} == 8'h00);
    {r.sec_t, r.sec_o} = bcd2_dec({t.sec_t, t.sec_o}, SEC_TENS_MAX);
    {r.min_t, r.min_o} = borrow ? bcd2_dec({t.min_t, t.min_o}, BCD_MAX)
                                : {t.min_t, t.min_o};
    return r;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Button-pulse inputs and display/status outputs of the countdown timer core.
interface bcd_countdown_timer_if;
  import timer_pkg::*;

  logic   start_i;
  logic   inc_sec_i;
  logic   inc_min_i;
  logic   clear_i;
  time_t  digits_o;
  state_e state_o;
  logic   running_o;
  logic   alarm_o;
  logic   done_o;

  modport master (
    output start_i, inc_sec_i, inc_min_i, clear_i,
    input  digits_o, state_o, running_o, alarm_o, done_o
  );

  modport slave (
    input  start_i, inc_sec_i, inc_min_i, clear_i,
    output digits_o, state_o, running_o, alarm_o, done_o
  );

endinterface

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles; holds while disabled.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_c_o
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick_c_o = en_i && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS countdown timer: set/run/pause/alarm state machine and BCD time datapath.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned MAX_MIN    = 99,
  parameter int unsigned ALARM_SECS = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  bcd_countdown_timer_if.slave   bus
);

  localparam logic [7:0] SEC_MAX_BCD = {SEC_TENS_MAX, BCD_MAX};
  localparam logic [7:0] MIN_MAX_BCD = 8'(((MAX_MIN / 10) << 4) | (MAX_MIN % 10));
  localparam int unsigned ALM_W = $clog2(ALARM_SECS + 1);
  localparam logic [ALM_W-1:0] ALM_LAST = ALM_W'(ALARM_SECS - 1);

  state_e           state_q;
  time_t            time_q;
  time_t            preset_q;
  logic [ALM_W-1:0] alarm_cnt_q;
  logic             running_q;
  logic             alarm_q;
  logic             done_q;

  logic tick_c;
  logic pre_en_c;
  logic pre_clr_c;
  logic time_zero_c;
  logic time_one_c;

  assign time_zero_c = (time_q == TIME_ZERO);
  assign time_one_c  = (time_q == TIME_ONE);

  // Prescaler runs in RUN/ALARM, restarts on a fresh start, on alarm entry and on clear.
  assign pre_en_c  = (state_q == ST_RUN) || (state_q == ST_ALARM);
  assign pre_clr_c = bus.clear_i
                  || ((state_q == ST_IDLE) && bus.start_i && !time_zero_c)
                  || ((state_q == ST_RUN) && !bus.start_i && tick_c && time_one_c);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .en_i     (pre_en_c),
    .clr_i    (pre_clr_c),
    .tick_c_o (tick_c)
  );

  // Priority per cycle: clear > start > tick > increments.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      time_q      <= TIME_ZERO;
      preset_q    <= TIME_ZERO;
      alarm_cnt_q <= '0;
      running_q   <= 1'b0;
      alarm_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.clear_i) begin
        state_q   <= ST_IDLE;
        time_q    <= TIME_ZERO;
        preset_q  <= TIME_ZERO;
        running_q <= 1'b0;
        alarm_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.start_i) begin
              if (!time_zero_c) begin
                preset_q  <= time_q;
                state_q   <= ST_RUN;
                running_q <= 1'b1;
              end
            end else begin
              if (bus.inc_sec_i)
                {time_q.sec_t, time_q.sec_o} <= bcd2_inc({time_q.sec_t, time_q.sec_o}, SEC_MAX_BCD);
              if (bus.inc_min_i)
                {time_q.min_t, time_q.min_o} <= bcd2_inc({time_q.min_t, time_q.min_o}, MIN_MAX_BCD);
            end
          end
          ST_RUN: begin
            if (bus.start_i) begin
              state_q   <= ST_PAUSE;
              running_q <= 1'b0;
            end else if (tick_c) begin
              if (time_one_c) begin
                time_q      <= TIME_ZERO;
                state_q     <= ST_ALARM;
                running_q   <= 1'b0;
                alarm_q     <= 1'b1;
                done_q      <= 1'b1;
                alarm_cnt_q <= '0;
              end else begin
                time_q <= time_dec(time_q);
              end
            end
          end
          ST_PAUSE: begin
            if (bus.start_i) begin
              state_q   <= ST_RUN;
              running_q <= 1'b1;
            end
          end
          ST_ALARM: begin
            if (bus.start_i || (tick_c && (alarm_cnt_q == ALM_LAST))) begin
              state_q <= ST_IDLE;
              time_q  <= preset_q;
              alarm_q <= 1'b0;
            end else if (tick_c) begin
              alarm_cnt_q <= alarm_cnt_q + ALM_W'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.digits_o  = time_q;
  assign bus.state_o   = state_q;
  assign bus.running_o = running_q;
  assign bus.alarm_o   = alarm_q;
  assign bus.done_o    = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a monitor checks them.
module tb_bcd_countdown_timer;
  import timer_pkg::*;

  localparam logic [1:0] IDL = 2'd0;
  localparam logic [1:0] RN  = 2'd1;
  localparam logic [1:0] PS  = 2'd2;
  localparam logic [1:0] AL  = 2'd3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bcd_countdown_timer_if bus();

  bcd_countdown_timer #(
    .TICK_DIV   (4),
    .MAX_MIN    (99),
    .ALARM_SECS (2)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    int          tgt;
    logic [20:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [20:0] pack(input logic [15:0] d, input logic [1:0] s,
                                       input logic r, input logic a, input logic dn);
    return {d, s, r, a, dn};
  endfunction

  // Monitor: after every edge, compare all expectations due at this edge.
  exp_t        mon_e;
  logic [20:0] mon_act;
  always begin
    @(posedge clk);
    cyc++;
    #2;
    while (q.size() > 0 && q[0].tgt <= cyc) begin
      mon_e   = q.pop_front();
      mon_act = pack(bus.digits_o, bus.state_o, bus.running_o, bus.alarm_o, bus.done_o);
      checks++;
      if (mon_act !== mon_e.val) begin
        errors++;
        $display("FAIL %s @edge %0d: got digits=%h state=%0d run=%b alarm=%b done=%b, expected digits=%h state=%0d run=%b alarm=%b done=%b",
                 mon_e.name, cyc, mon_act[20:5], mon_act[4:3], mon_act[2], mon_act[1], mon_act[0],
                 mon_e.val[20:5], mon_e.val[4:3], mon_e.val[2], mon_e.val[1], mon_e.val[0]);
      end
    end
  end

  task automatic ex(input int d, input logic [15:0] dig, input logic [1:0] st,
                    input logic r, input logic a, input logic dn, input string nm);
    exp_t e;
    e.tgt  = cyc + d;
    e.val  = pack(dig, st, r, a, dn);
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic drv(input logic s, input logic is, input logic im, input logic c);
    @(negedge clk);
    bus.start_i   = s;
    bus.inc_sec_i = is;
    bus.inc_min_i = im;
    bus.clear_i   = c;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) drv(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.start_i   = 1'b0;
    bus.inc_sec_i = 1'b0;
    bus.inc_min_i = 1'b0;
    bus.clear_i   = 1'b0;

    // Reset state
    wait_cyc(2);
    ex(1, 16'h0000, IDL, 0, 0, 0, "reset_state");
    wait_cyc(1);
    rst = 1'b0;

    // Setting: seconds wrap without carry, minutes wrap at MAX_MIN, both together
    repeat (60) drv(0, 1, 0, 0);
    ex(1, 16'h0000, IDL, 0, 0, 0, "sec_wrap_60");
    drv(0, 1, 0, 0);
    ex(1, 16'h0001, IDL, 0, 0, 0, "sec_61");
    repeat (99) drv(0, 0, 1, 0);
    ex(1, 16'h9901, IDL, 0, 0, 0, "min_99");
    drv(0, 0, 1, 0);
    ex(1, 16'h0001, IDL, 0, 0, 0, "min_wrap_100");
    drv(0, 1, 1, 0);
    ex(1, 16'h0102, IDL, 0, 0, 0, "both_inc");
    drv(0, 0, 0, 1);
    ex(1, 16'h0000, IDL, 0, 0, 0, "clear_idle");
    drv(0, 0, 1, 0);
    ex(1, 16'h0100, IDL, 0, 0, 0, "set_0100");

    // Full 01:00 run into alarm, then preset recall
    drv(1, 0, 0, 0);
    ex(1, 16'h0100, RN, 1, 0, 0, "start_0100");
    drv(0, 1, 0, 0);
    ex(1,   16'h0100, RN, 1, 0, 0, "inc_ignored_run");
    ex(4,   16'h0059, RN, 1, 0, 0, "first_tick");
    ex(120, 16'h0030, RN, 1, 0, 0, "half_way");
    ex(240, 16'h0000, AL, 0, 1, 1, "done_pulse");
    ex(241, 16'h0000, AL, 0, 1, 0, "done_one_cycle");
    ex(247, 16'h0000, AL, 0, 1, 0, "alarm_hold");
    ex(248, 16'h0100, IDL, 0, 0, 0, "alarm_expire_recall");
    wait_cyc(250);

    // Pause holds time and prescaler phase
    drv(0, 0, 0, 1);
    ex(1, 16'h0000, IDL, 0, 0, 0, "clear_after_alarm");
    repeat (5) drv(0, 1, 0, 0);
    drv(1, 0, 0, 0);
    ex(1, 16'h0005, RN, 1, 0, 0, "start_0005");
    ex(5, 16'h0004, RN, 1, 0, 0, "tick_0004");
    wait_cyc(5);
    drv(1, 0, 0, 0);
    ex(1,  16'h0004, PS, 0, 0, 0, "pause");
    ex(20, 16'h0004, PS, 0, 0, 0, "pause_hold");
    wait_cyc(20);
    drv(1, 0, 0, 0);
    ex(1, 16'h0004, RN, 1, 0, 0, "resume");
    ex(2, 16'h0004, RN, 1, 0, 0, "resume_no_tick_yet");
    ex(3, 16'h0003, RN, 1, 0, 0, "resume_held_phase");
    wait_cyc(3);
    drv(0, 0, 0, 1);
    ex(1, 16'h0000, IDL, 0, 0, 0, "clear_run");

    // Start coincident with tick pauses without decrement; clear beats start
    repeat (3) drv(0, 1, 0, 0);
    drv(1, 0, 0, 0);
    ex(1, 16'h0003, RN, 1, 0, 0, "start_0003");
    ex(5, 16'h0002, RN, 1, 0, 0, "tick_0002");
    wait_cyc(7);
    drv(1, 0, 0, 0);
    ex(1, 16'h0002, PS, 0, 0, 0, "pause_on_tick");
    drv(1, 0, 0, 1);
    ex(1, 16'h0000, IDL, 0, 0, 0, "clear_over_start");
    drv(1, 0, 0, 0);
    ex(1, 16'h0000, IDL, 0, 0, 0, "start_zero_after_clear");
    wait_cyc(2);

    // Reset mid-run aborts at once
    repeat (31) drv(0, 1, 0, 0);
    drv(1, 0, 0, 0);
    ex(1, 16'h0031, RN, 1, 0, 0, "start_0031");
    ex(5, 16'h0030, RN, 1, 0, 0, "tick_0030");
    wait_cyc(4);
    drv(0, 0, 0, 0);
    rst = 1'b1;
    ex(1, 16'h0000, IDL, 0, 0, 0, "reset_mid_run");
    drv(1, 0, 0, 0);
    rst = 1'b0;
    ex(1, 16'h0000, IDL, 0, 0, 0, "start_at_zero");
    ex(3, 16'h0000, IDL, 0, 0, 0, "still_idle");
    wait_cyc(6);

    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending_expectations: got %0d unchecked, expected 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
